// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared ALU control codes and multiply/divide unit types.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } muldiv_op_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle signed mult/div unit owning the HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNTW-1:0] C_LAST = CNTW'(WIDTH - 1);

  muldiv_state_t    r_state, w_state_nxt;
  muldiv_op_t       r_op, w_op_in;
  logic [WIDTH-1:0] r_opd;      // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0] r_acc_hi;   // partial product / remainder
  logic [WIDTH-1:0] r_acc_lo;   // multiplier / quotient
  logic [WIDTH-1:0] r_srca;
  logic [CNTW-1:0]  r_cnt;
  logic             r_sa, r_sb, r_dz;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done, r_divzero;

  logic             w_accept;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fin;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (r_cnt == C_LAST) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != IDLE);
    w_accept = (r_state == IDLE) && start &&
               ((alucontrol == ALU_MULT) || (alucontrol == ALU_DIV));
  end

  // ----------------------------------------------------------- datapath ----
  assign w_op_in  = (alucontrol == ALU_DIV) ? OP_DIV : OP_MULT;
  assign w_mag_a  = srca[WIDTH-1] ? -srca : srca;
  assign w_mag_b  = srcb[WIDTH-1] ? -srcb : srcb;

  assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opd} : '0);
  // Magnitudes never exceed 2**(WIDTH-1), so the remainder's top bit is always 0.
  assign w_rem_sh = {1'b0, r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_opd};

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fin = (r_sa ^ r_sb) ? -w_prod : w_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= OP_MULT;
      r_opd     <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_srca    <= '0;
      r_cnt     <= '0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= w_op_in;
            r_opd    <= (w_op_in == OP_MULT) ? w_mag_a : w_mag_b;
            r_acc_hi <= '0;
            r_acc_lo <= (w_op_in == OP_MULT) ? w_mag_b : w_mag_a;
            r_srca   <= srca;
            r_sa     <= srca[WIDTH-1];
            r_sb     <= srcb[WIDTH-1];
            r_dz     <= (srcb == '0);
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (r_op == OP_MULT) begin
            r_acc_hi <= w_sum[WIDTH:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
          end else begin
            r_acc_hi <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_diff[WIDTH]};
          end
        end
        FIN: begin
          r_done <= 1'b1;
          if (r_op == OP_MULT) begin
            r_hi <= w_prod_fin[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fin[WIDTH-1:0];
          end else if (r_dz) begin
            r_hi      <= r_srca;
            r_lo      <= '1;
            r_divzero <= 1'b1;
          end else begin
            r_hi <= r_sa ? -r_acc_hi : r_acc_hi;
            r_lo <= (r_sa ^ r_sb) ? -r_acc_lo : r_acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign done    = r_done;
  assign divzero = r_divzero;

endmodule
`default_nettype wire
